edac_scrubber: RTL

- Background scrub controller for the EDAC-protected RAM; the read-side counterpart of the encoder write path.
- Periodically reads one codeword and observes the decoder outputs (errFlag, correctable, re_code).
- Writes corrected codewords back to RAM and counts correctable and uncorrectable events.
- Sits between the user port and the RAM arbiter, yielding to user accesses every cycle.

---
 rtl/edac_scrubber.sv | 132 +++++++++++++
 1 files changed

// File: rtl/edac_scrubber.sv
// Background scrub controller: periodically reads one EDAC codeword, writes corrected
// data back, and counts correctable/uncorrectable events. Yields to the user port every cycle.
module edac_scrubber #(
  parameter int DAT_WIDTH    = 16,
  parameter int PAR_WIDTH    = 5,
  parameter int RAM_LOGDEPTH = 8,
  parameter int RD_LAT       = 2,
  parameter int SCRUB_PERIOD = 1024,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           user_rEn,
  input  logic                           user_wEn,
  input  logic [RAM_LOGDEPTH-1:0]        user_wA,
  output logic                           scrub_rEn,
  output logic [RAM_LOGDEPTH-1:0]        scrub_rA,
  input  logic [DAT_WIDTH+PAR_WIDTH-1:0] dec_re_code,
  input  logic                           dec_errFlag,
  input  logic                           dec_correctable,
  output logic                           scrub_wEn,
  output logic [RAM_LOGDEPTH-1:0]        scrub_wA,
  output logic [DAT_WIDTH+PAR_WIDTH-1:0] scrub_wD,
  output logic [CNT_WIDTH-1:0]           corr_cnt,
  output logic [CNT_WIDTH-1:0]           uncorr_cnt,
  output logic                           uncorr_flag,
  output logic [RAM_LOGDEPTH-1:0]        uncorr_addr,
  output logic                           sweep_done,
  output logic [2:0]                     dbgState
);

  localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam int LW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    WAIT    = 3'd2,
    CHECK   = 3'd3,
    WRITE   = 3'd4,
    ADVANCE = 3'd5
  } state_t;

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [LW-1:0]           waitCnt;
  logic [RAM_LOGDEPTH-1:0] addr;
  logic                    hazard;
  logic                    userBusy;
  logic                    userHitsAddr;

  assign userBusy     = user_rEn | user_wEn;
  assign userHitsAddr = user_wEn & (user_wA == addr);

  // Handshake: scrub_rEn / scrub_wEn are one-cycle grants. They rise only in a cycle the
  // user port leaves free, and the arbiter accepts them unconditionally in that cycle.
  assign scrub_rEn = (state == READ) & ~userBusy;
  assign scrub_wEn = (state == WRITE) & ~hazard & ~userBusy & ~userHitsAddr;
  assign scrub_rA  = addr;
  assign scrub_wA  = addr;
  assign dbgState  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      waitCnt     <= '0;
      addr        <= '0;
      hazard      <= 1'b0;
      scrub_wD    <= '0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
      uncorr_flag <= 1'b0;
      uncorr_addr <= '0;
      sweep_done  <= 1'b0;
    end else begin
      uncorr_flag <= 1'b0;
      sweep_done  <= 1'b0;
      // A user write to the word in flight makes our corrected copy stale.
      if ((state == WAIT || state == CHECK || state == WRITE) && userHitsAddr)
        hazard <= 1'b1;
      case (state)
        IDLE: begin
          if (!enable) begin
            timer <= '0;
          end else if (timer == TW'(SCRUB_PERIOD - 1)) begin
            timer <= '0;
            state <= READ;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        READ: begin
          if (scrub_rEn) begin
            hazard  <= 1'b0;
            waitCnt <= '0;
            state   <= (RD_LAT == 1) ? CHECK : WAIT;
          end
        end
        WAIT: begin
          if (int'(waitCnt) >= RD_LAT - 2) state <= CHECK;
          else waitCnt <= waitCnt + LW'(1);
        end
        CHECK: begin
          if (!dec_errFlag) begin
            state <= ADVANCE;
          end else if (dec_correctable) begin
            scrub_wD <= dec_re_code;
            if (corr_cnt != '1) corr_cnt <= corr_cnt + CNT_WIDTH'(1);
            state <= WRITE;
          end else begin
            if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
            uncorr_addr <= addr;
            uncorr_flag <= 1'b1;
            state       <= ADVANCE;
          end
        end
        WRITE: begin
          if (hazard || scrub_wEn) state <= ADVANCE;
        end
        ADVANCE: begin
          addr <= addr + RAM_LOGDEPTH'(1);
          if (addr == '1) sweep_done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
